digit_counter: RTL and testbench

//  Upstream source for the digits VGA renderer: free-running BCD counter advanced by a

---
 rtl/digit_counter.sv | 110 +++++++++++
 tb/tb_digit_counter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_counter.sv
`default_nettype none
// ============================================================================
// Module      : digit_counter
// Description : Prescaled free-running BCD counter feeding the digits renderer.
//               Optional frame latch via macro DIGIT_COUNTER_FRAME_LATCH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_counter #(
    parameter int CLK_HZ  = 25_000_000,
    parameter int TICK_HZ = 1,
    parameter int NDIGITS = 4
) (
    input  logic                 Clock,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 clear,
    input  logic                 vsync,
    output logic [4*NDIGITS-1:0] digits,
    output logic                 tick,
    output logic                 overflow
);

    localparam int              c_div  = CLK_HZ / TICK_HZ;
    localparam int              c_pw   = (c_div > 1) ? $clog2(c_div) : 1;
    localparam logic [c_pw-1:0] c_pmax = c_pw'(c_div - 1);

    logic [c_pw-1:0]      r_presc;
    logic [4*NDIGITS-1:0] r_count;
    logic                 r_tick;
    logic                 r_overflow;

    logic [4*NDIGITS-1:0] w_count_inc;
    logic                 w_carry;
    logic                 w_wrap;
    logic                 w_step;

    assign w_wrap = (r_presc == c_pmax);
    // clear wins over a coincident step, so no tick or overflow escapes
    assign w_step = run & w_wrap & ~clear;

    // Ripple BCD increment; a carry out of the top digit means all-9s wrap
    always_comb begin
        w_count_inc = r_count;
        w_carry     = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (w_carry) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_count_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_count_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    w_carry               = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            r_presc    <= '0;
            r_count    <= '0;
            r_tick     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (clear) begin
                r_presc <= '0;
                r_count <= '0;
            end else if (run) begin
                r_presc <= w_wrap ? '0 : r_presc + c_pw'(1);
                if (w_wrap) begin
                    r_count <= w_count_inc;
                end
            end
            r_tick     <= w_step;
            r_overflow <= w_step & w_carry;
        end
    end

    assign tick     = r_tick;
    assign overflow = r_overflow;

`ifdef DIGIT_COUNTER_FRAME_LATCH_EN
    logic                 r_vsync_q;
    logic                 r_latch;
    logic [4*NDIGITS-1:0] r_digits;

    // History resets high so releasing reset with vsync low is not an edge
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            r_vsync_q <= 1'b1;
            r_latch   <= 1'b0;
            r_digits  <= '0;
        end else begin
            r_vsync_q <= vsync;
            r_latch   <= r_vsync_q & ~vsync;
            if (r_latch) begin
                r_digits <= r_count;
            end
        end
    end

    assign digits = r_digits;
`else
    logic w_unused_vsync;

    assign w_unused_vsync = vsync;
    assign digits         = r_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_digit_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_counter
// Description : Scoreboard bench for digit_counter (DIV=10 main, DIV=2 wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_counter;

`ifdef DIGIT_COUNTER_FRAME_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        reset;
    logic        run;
    logic        clear;
    logic        vsync;
    logic [15:0] digits;
    logic        tick;
    logic        overflow;

    logic        f_run;
    logic        f_clear;
    logic        f_vsync;
    logic [15:0] f_digits;
    logic        f_tick;
    logic        f_overflow;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic        ovf;
        logic [15:0] dig;
    } exp_t;

    exp_t sb[$];

    digit_counter #(.CLK_HZ(10), .TICK_HZ(1), .NDIGITS(4)) u_dut (
        .Clock    (Clock),
        .reset    (reset),
        .run      (run),
        .clear    (clear),
        .vsync    (vsync),
        .digits   (digits),
        .tick     (tick),
        .overflow (overflow)
    );

    // Short-period instance so the all-9s wrap is reachable quickly
    digit_counter #(.CLK_HZ(2), .TICK_HZ(1), .NDIGITS(4)) u_fast (
        .Clock    (Clock),
        .reset    (reset),
        .run      (f_run),
        .clear    (f_clear),
        .vsync    (f_vsync),
        .digits   (f_digits),
        .tick     (f_tick),
        .overflow (f_overflow)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [15:0] bcd(int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(int c, int v);
        exp_t e;
        e.cyc = c;
        e.ovf = 1'b0;
        e.dig = bcd(v);
        sb.push_back(e);
    endtask

    task automatic goto(int t);
        do @(negedge Clock); while (cyc < t);
    endtask

    always @(negedge Clock) begin
        if (sb.size() > 0 && !tick && cyc > sb[0].cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_tick: tick absent, expected one at cycle %0d", sb[0].cyc);
            void'(sb.pop_front());
        end
        if (tick) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick: tick at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("tick_cycle", cyc, e.cyc);
                check("tick_overflow", int'(overflow), int'(e.ovf));
`ifndef DIGIT_COUNTER_FRAME_LATCH_EN
                check("tick_digits", int'(digits), int'(e.dig));
`endif
            end
        end else if (overflow) begin
            checks++;
            errors++;
            $display("FAIL stray_overflow: overflow=1 without tick at cycle %0d, expected 0", cyc);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        int n;
        int ft;
        int fo;

        reset   = 1'b0;
        run     = 1'b1;
        clear   = 1'b0;
        vsync   = 1'b1;
        f_run   = 1'b0;
        f_clear = 1'b0;
        f_vsync = 1'b1;

        repeat (3) @(negedge Clock);
        check("rst_digits", int'(digits), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_fast_digits", int'(f_digits), 0);

        // Release: first tick a full period later, then every 10 cycles
        c0    = cyc;
        reset = 1'b1;
        for (int i = 1; i <= 13; i++) push(c0 + 10 * i, i);

        goto(c0 + 133);
        check("hold_no_vsync", int'(digits), LATCH ? 0 : int'(bcd(13)));
        vsync = 1'b0;
        for (int i = 14; i <= 41; i++) push(c0 + 10 * i, i);
        goto(c0 + 134);
        check("latch_lat1", int'(digits), LATCH ? 0 : int'(bcd(13)));
        goto(c0 + 135);
        check("latch_13", int'(digits), int'(bcd(13)));
        goto(c0 + 145);
        check("hold_low", int'(digits), int'(bcd(LATCH ? 13 : 14)));

        // Second falling edge lands its latch on a step edge
        goto(c0 + 146);
        vsync = 1'b1;
        goto(c0 + 148);
        vsync = 1'b0;
        goto(c0 + 150);
        check("latch_coincide", int'(digits), int'(bcd(LATCH ? 14 : 15)));
        goto(c0 + 161);
        check("hold_low2", int'(digits), int'(bcd(LATCH ? 14 : 16)));

        // Clear on the step cycle of count 41 -> 42
        goto(c0 + 419);
        check("pre_clear", int'(digits), int'(bcd(LATCH ? 14 : 41)));
        clear = 1'b1;
        goto(c0 + 420);
        clear = 1'b0;
        push(c0 + 430, 1);
        goto(c0 + 421);
        check("after_clear", int'(digits), int'(bcd(LATCH ? 14 : 0)));
        vsync = 1'b1;
        goto(c0 + 423);
        vsync = 1'b0;
        goto(c0 + 425);
        check("latch_clear", int'(digits), 0);

        // Freeze at prescaler 6 for 50 cycles
        goto(c0 + 436);
        run = 1'b0;
        goto(c0 + 486);
        run = 1'b1;
        push(c0 + 490, 2);
        push(c0 + 500, 3);

        // Clear while stopped
        goto(c0 + 503);
        run   = 1'b0;
        clear = 1'b1;
        goto(c0 + 504);
        clear = 1'b0;
        goto(c0 + 505);
        check("clear_run0", int'(digits), 0);
        goto(c0 + 510);
        run = 1'b1;
        push(c0 + 520, 1);
        goto(c0 + 521);
        vsync = 1'b1;
        goto(c0 + 523);
        vsync = 1'b0;
        goto(c0 + 525);
        check("latch_1", int'(digits), int'(bcd(1)));

        // Asynchronous reset away from any clock edge
        goto(c0 + 526);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_digits", int'(digits), 0);
        check("async_rst_tick", int'(tick), 0);
        check("sb_drained", sb.size(), 0);
        vsync = 1'b1;
        goto(c0 + 530);
        c1    = cyc;
        reset = 1'b1;
        push(c1 + 10, 1);
        push(c1 + 20, 2);
        goto(c1 + 25);
        check("restart_digits", int'(digits), LATCH ? 0 : int'(bcd(2)));
        run = 1'b0;

        // Wrap test on the fast instance: 9999 steps then one more
        f_clear = 1'b1;
        @(negedge Clock);
        f_clear = 1'b0;
        f_run   = 1'b1;
        ft = 0;
        fo = 0;
        n  = 0;
        while (ft < 9999 && n < 25000) begin
            @(negedge Clock);
            n++;
            if (f_tick) ft++;
            if (f_overflow) fo++;
        end
        check("fast_ticks", ft, 9999);
        check("fast_no_early_ovf", fo, 0);
        f_run   = 1'b0;
        f_vsync = 1'b0;
        repeat (3) @(negedge Clock);
        check("pre_wrap_digits", int'(f_digits), 32'h9999);
        f_vsync = 1'b1;
        f_run   = 1'b1;
        @(negedge Clock);
        check("wrap_wait_tick", int'(f_tick), 0);
        @(negedge Clock);
        check("wrap_tick", int'(f_tick), 1);
        check("wrap_overflow", int'(f_overflow), 1);
`ifndef DIGIT_COUNTER_FRAME_LATCH_EN
        check("wrap_digits", int'(f_digits), 0);
`endif
        f_run = 1'b0;
        @(negedge Clock);
        check("post_wrap_tick", int'(f_tick), 0);
        check("post_wrap_overflow", int'(f_overflow), 0);
        f_vsync = 1'b0;
        repeat (2) @(negedge Clock);
        check("post_wrap_latch", int'(f_digits), 0);

        repeat (5) @(negedge Clock);
        check("sb_final", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
